// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Opcode values match the case items of the main decoder.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    KIND_LW    = 3'd0,
    KIND_SW    = 3'd1,
    KIND_RTYPE = 3'd2,
    KIND_BEQ   = 3'd3,
    KIND_ITYPE = 3'd4,
    KIND_JAL   = 3'd5,
    KIND_RSV6  = 3'd6,
    KIND_RSV7  = 3'd7
  } kind_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;

  function automatic logic imm_in_range(input logic [31:0] imm,
                                        input logic signed [31:0] lo,
                                        input logic signed [31:0] hi);
    return ($signed(imm) >= lo) && ($signed(imm) <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Places immediate and funct bits of a descriptor into their instruction
// positions and judges whether the immediate is encodable for that kind.
module imm_pack
  import instr_enc_pkg::*;
(
  input  kind_e       kind,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [31:0] imm,
  output logic [31:0] field,
  output logic        legal
);

  // Per-kind immediate scatter and range check
  always_comb begin
    field = 32'd0;
    legal = 1'b0;
    case (kind)
      KIND_LW: begin
        field = {imm[11:0], 5'd0, F3_LW, 5'd0, 7'd0};
        legal = imm_in_range(imm, -32'sd2048, 32'sd2047);
      end
      KIND_SW: begin
        field = {imm[11:5], 5'd0, 5'd0, F3_SW, imm[4:0], 7'd0};
        legal = imm_in_range(imm, -32'sd2048, 32'sd2047);
      end
      KIND_RTYPE: begin
        field = {1'b0, funct7b5, 5'd0, 5'd0, 5'd0, funct3, 5'd0, 7'd0};
        legal = 1'b1;
      end
      KIND_BEQ: begin
        field = {imm[12], imm[10:5], 5'd0, 5'd0, F3_BEQ, imm[4:1], imm[11], 7'd0};
        legal = (imm[0] == 1'b0) && imm_in_range(imm, -32'sd4096, 32'sd4094);
      end
      KIND_ITYPE: begin
        if ((funct3 == F3_SLLI) || (funct3 == F3_SRXI)) begin
          // srai is the only shift carrying instr[30]; slli keeps it zero
          field = {1'b0, (funct3 == F3_SRXI) ? funct7b5 : 1'b0, 5'd0,
                   imm[4:0], 5'd0, funct3, 5'd0, 7'd0};
          legal = imm_in_range(imm, 32'sd0, 32'sd31);
        end else begin
          field = {imm[11:0], 5'd0, funct3, 5'd0, 7'd0};
          legal = imm_in_range(imm, -32'sd2048, 32'sd2047);
        end
      end
      KIND_JAL: begin
        field = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'd0};
        legal = (imm[0] == 1'b0) && imm_in_range(imm, -32'sd1048576, 32'sd1048574);
      end
      default: begin
        field = 32'd0;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I descriptor-to-machine-word encoder with a one-stage registered
// valid/ready output, sequential word addresses and drop accounting.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  drop_cnt
);

  kind_e              kind_s;
  logic [31:0]        field_s;
  logic               legal_s;
  logic [31:0]        reg_s;
  logic [6:0]         opcode_s;
  logic [31:0]        word_s;
  logic               accept_s;
  logic               out_hs_s;
  logic               out_valid_r;
  logic [31:0]        out_instr_r;
  logic [ADDR_W-1:0]  out_addr_r;
  logic               err_sticky_r;
  logic [CNT_W-1:0]   drop_cnt_r;

  assign kind_s = kind_e'(in_kind);

  imm_pack u_imm_pack (
    .kind     (kind_s),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .imm      (in_imm),
    .field    (field_s),
    .legal    (legal_s)
  );

  // Register fields and opcode per kind
  always_comb begin
    reg_s    = 32'd0;
    opcode_s = 7'd0;
    case (kind_s)
      KIND_LW: begin
        opcode_s = OP_LOAD;
        reg_s    = {12'd0, in_rs1, 3'd0, in_rd, 7'd0};
      end
      KIND_SW: begin
        opcode_s = OP_STORE;
        reg_s    = {7'd0, in_rs2, in_rs1, 3'd0, 5'd0, 7'd0};
      end
      KIND_RTYPE: begin
        opcode_s = OP_RTYPE;
        reg_s    = {7'd0, in_rs2, in_rs1, 3'd0, in_rd, 7'd0};
      end
      KIND_BEQ: begin
        opcode_s = OP_BRANCH;
        reg_s    = {7'd0, in_rs2, in_rs1, 3'd0, 5'd0, 7'd0};
      end
      KIND_ITYPE: begin
        opcode_s = OP_ITYPE;
        reg_s    = {12'd0, in_rs1, 3'd0, in_rd, 7'd0};
      end
      KIND_JAL: begin
        opcode_s = OP_JAL;
        reg_s    = {20'd0, in_rd, 7'd0};
      end
      default: begin
        opcode_s = 7'd0;
        reg_s    = 32'd0;
      end
    endcase
  end

  assign word_s   = field_s | reg_s | {25'd0, opcode_s};
  assign in_ready = !clr && (!out_valid_r || out_ready);
  assign accept_s = in_valid && in_ready;
  assign out_hs_s = out_valid_r && out_ready;

  // Output stage, address counter and drop accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_instr_r  <= 32'd0;
      out_addr_r   <= {ADDR_W{1'b0}};
      err_sticky_r <= 1'b0;
      drop_cnt_r   <= {CNT_W{1'b0}};
    end else if (clr) begin
      // a handshake coinciding with clr is discarded along with the word
      out_valid_r  <= 1'b0;
      out_addr_r   <= {ADDR_W{1'b0}};
      err_sticky_r <= 1'b0;
      drop_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      if (out_hs_s) begin
        out_addr_r <= out_addr_r + ADDR_W'(1);
      end
      if (accept_s && legal_s) begin
        out_valid_r <= 1'b1;
        out_instr_r <= word_s;
      end else if (out_hs_s) begin
        out_valid_r <= 1'b0;
      end
      if (accept_s && !legal_s) begin
        err_sticky_r <= 1'b1;
        if (drop_cnt_r != {CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = out_valid_r;
  assign out_instr  = out_instr_r;
  assign out_addr   = out_addr_r;
  assign err_sticky = err_sticky_r;
  assign drop_cnt   = drop_cnt_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expected words from a
// field-arithmetic reference model, monitor checks whatever the DUT presents.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_ready, in_funct7b5;
  logic [2:0]  in_kind, in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, err_sticky;
  logic [31:0] out_instr;
  logic [7:0]  out_addr, drop_cnt;

  instr_encoder #(.ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_sticky(err_sticky), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [7:0] addr; } exp_t;
  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] n_words = 8'd0;
  logic       e_err = 1'b0;
  logic [7:0] e_drop = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fld(input int v, input int lo, input int n);
    return 32'((v >>> lo) & ((1 << n) - 1));
  endfunction

  // Reference encoder: fields placed by shift-and-add from the ISA tables
  task automatic model(input logic [2:0] k, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input int imm, output logic legal, output logic [31:0] w);
    int r1, r2, d;
    r1 = int'(rs1) << 15; r2 = int'(rs2) << 20; d = int'(rd) << 7;
    legal = 1'b0; w = 32'd0;
    case (k)
      3'd0: begin legal = imm >= -2048 && imm <= 2047;
        w = (fld(imm,0,12) << 20) + r1 + (2 << 12) + d + 3; end
      3'd1: begin legal = imm >= -2048 && imm <= 2047;
        w = (fld(imm,5,7) << 25) + r2 + r1 + (2 << 12) + (fld(imm,0,5) << 7) + 35; end
      3'd2: begin legal = 1'b1;
        w = (int'(f7) << 30) + r2 + r1 + (int'(f3) << 12) + d + 51; end
      3'd3: begin legal = (imm % 2 == 0) && imm >= -4096 && imm <= 4094;
        w = (fld(imm,12,1) << 31) + (fld(imm,5,6) << 25) + r2 + r1
            + (fld(imm,1,4) << 8) + (fld(imm,11,1) << 7) + 99; end
      3'd4: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          legal = imm >= 0 && imm <= 31;
          w = ((f3 == 3'd5 && f7) ? 32'h4000_0000 : 32'd0) + (fld(imm,0,5) << 20)
              + r1 + (int'(f3) << 12) + d + 19;
        end else begin
          legal = imm >= -2048 && imm <= 2047;
          w = (fld(imm,0,12) << 20) + r1 + (int'(f3) << 12) + d + 19;
        end
      end
      3'd5: begin legal = (imm % 2 == 0) && imm >= -1048576 && imm <= 1048574;
        w = (fld(imm,20,1) << 31) + (fld(imm,1,10) << 21) + (fld(imm,11,1) << 20)
            + (fld(imm,12,8) << 12) + d + 111; end
      default: begin legal = 1'b0; w = 32'd0; end
    endcase
  endtask

  // One cycle: verify state from last edge, drive inputs, update the model
  task automatic step(input logic v, input logic [2:0] k, input logic [2:0] f3, input logic f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input int imm, input logic ordy, input logic c,
                      input logic use_k, input logic [31:0] k_instr);
    logic exp_rdy, legal;
    logic [31:0] w;
    @(posedge clk); #1;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("err_sticky", 32'(err_sticky), 32'(e_err));
    check("drop_cnt", 32'(drop_cnt), 32'(e_drop));
    in_valid = v; in_kind = k; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; out_ready = ordy; clr = c;
    #1;
    exp_rdy = !c && (q.size() == 0 || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (c) begin
      q.delete(); n_words = 8'd0; e_err = 1'b0; e_drop = 8'd0;
    end else if (v && exp_rdy) begin
      model(k, f3, f7, rd, rs1, rs2, imm, legal, w);
      if (legal) begin
        q.push_back('{instr: (use_k ? k_instr : w), addr: n_words});
        n_words++;
      end else begin
        e_err = 1'b1;
        if (e_drop != 8'hFF) e_drop++;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0, ordy, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: whatever the DUT presents must equal the scoreboard head
  always @(negedge clk) begin
    if (rst_n && !clr && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_word", out_instr, 32'hxxxx_xxxx);
      end else begin
        check("out_instr", out_instr, q[0].instr);
        check("out_addr", 32'(out_addr), 32'(q[0].addr));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  int bnd[21] = '{-1048577, -1048576, -4097, -4096, -2049, -2048, -1, 0, 1, 2, 31,
                  32, 2046, 2047, 2048, 4094, 4095, 4096, 1048574, 1048575, 1048576};

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_kind = 3'd0; in_funct3 = 3'd0;
    in_funct7b5 = 1'b0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // Directed cases with hand-computed words
    step(1, 3'd0, 0, 0, 5'd5, 5'd2, 5'd0, 8, 1, 0, 1, 32'h00812283);
    idle(1);
    step(1, 3'd2, 0, 0, 5'd3, 5'd1, 5'd2, 0, 1, 0, 1, 32'h002081B3);
    step(1, 3'd1, 0, 0, 5'd0, 5'd2, 5'd6, -4, 1, 0, 1, 32'hFE612E23);
    step(1, 3'd3, 0, 0, 5'd0, 5'd1, 5'd2, -8, 1, 0, 1, 32'hFE208CE3);
    repeat (3) step(1, 3'd5, 0, 0, 5'd1, 5'd0, 5'd0, 16, 0, 0, 1, 32'h010000EF);
    step(1, 3'd5, 0, 0, 5'd1, 5'd0, 5'd0, 16, 1, 0, 1, 32'h010000EF);
    idle(1);
    step(1, 3'd3, 0, 0, 5'd0, 5'd1, 5'd2, 3, 1, 0, 0, 32'd0);
    step(1, 3'd7, 0, 0, 5'd0, 5'd1, 5'd2, 0, 1, 0, 0, 32'd0);
    idle(1);
    step(1, 3'd4, 3'd5, 1, 5'd4, 5'd7, 5'd0, 31, 1, 0, 0, 32'd0);
    step(1, 3'd4, 3'd1, 1, 5'd4, 5'd7, 5'd0, 3, 0, 0, 0, 32'd0);
    step(1, 3'd0, 0, 0, 5'd9, 5'd9, 5'd0, 12, 0, 1, 0, 32'd0);
    step(1, 3'd0, 0, 0, 5'd5, 5'd2, 5'd0, 8, 1, 0, 1, 32'h00812283);
    idle(1);

    // Saturate the drop counter, then clear
    for (int i = 0; i < 300; i++)
      step(1, 3'($urandom_range(6, 7)), 0, 0, 5'd1, 5'd1, 5'd1, 0, 1'($urandom_range(0, 1)), 0, 0, 32'd0);
    step(0, 3'd0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 32'd0);

    // Randomized traffic, long enough to wrap the address counter
    for (int i = 0; i < 2500; i++) begin
      logic [2:0] k;
      int imm;
      k = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      case ($urandom_range(0, 3))
        0: imm = bnd[$urandom_range(0, 20)];
        1: imm = int'($urandom_range(0, 80)) - 40;
        2: imm = int'($urandom);
        default: imm = int'($urandom_range(0, 4094)) - 2048;
      endcase
      step(1'($urandom_range(0, 4) != 0), k, 3'($urandom), 1'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), imm,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 299) == 0), 0, 32'd0);
    end

    for (int i = 0; i < 8 && q.size() != 0; i++) idle(1);
    check("drain_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
